// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer carrying
// instruction word, PC and a PC-misalignment flag, with flush support.
module if_id_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [31:0]             in_instr,
    input  logic [31:0]             in_pc,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic                    out_misaligned,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic        mis_mem   [DEPTH];

    logic push;
    logic pop;

    // Handshakes; a full queue never accepts, even when the head pops this cycle.
    always_comb begin
        in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next pointer/occupancy; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
            mis_mem[wr_ptr_q]   <= (in_pc[1:0] != 2'b00);
        end
    end

    // Head entry presented directly; an empty queue shows a NOP at PC 0.
    always_comb begin
        out_instr      = NOP_INSTR;
        out_pc         = '0;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_instr      = instr_mem[rd_ptr_q];
            out_pc         = pc_mem[rd_ptr_q];
            out_misaligned = mis_mem[rd_ptr_q];
        end
        count = count_q;
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          out_misaligned;
    logic [CW-1:0] count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_ready       (in_ready),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_misaligned (out_misaligned),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model for the inputs currently driven.
    task automatic check_all(input string tag);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_mis;
        e_instr = 32'h0000_0013;
        e_pc    = 32'h0;
        e_mis   = 1'b0;
        if (q.size() != 0) begin
            e_instr = q[0].instr;
            e_pc    = q[0].pc;
            e_mis   = (q[0].pc[1:0] != 2'b00);
        end
        chk({tag, ".count"},     32'(count),          32'(q.size()));
        chk({tag, ".out_valid"}, 32'(out_valid),      32'(q.size() != 0));
        chk({tag, ".in_ready"},  32'(in_ready),       32'((q.size() < DEPTH) && !flush));
        chk({tag, ".out_instr"}, out_instr,           e_instr);
        chk({tag, ".out_pc"},    out_pc,              e_pc);
        chk({tag, ".out_mis"},   32'(out_misaligned), 32'(e_mis));
    endtask

    // One clock: drive at posedge+1, check at negedge, update model at the edge.
    task automatic step(input string tag, input logic vld, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = vld;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_all(tag);
        do_push = vld && (q.size() < DEPTH) && !fl;
        do_pop  = ordy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{instr: ins, pc: pc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words [4];
        words[0] = 32'h7856_3412;
        words[1] = 32'hF0DE_BC9A;
        words[2] = 32'h3322_1100;
        words[3] = 32'h7766_5544;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        check_all("reset");
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) step("fill", 1'b1, words[i], 32'(i * 4), 1'b0, 1'b0);
        check_all("full");
        chk("full.count", 32'(count), 32'd4);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.pc", out_pc, 32'h0);
        chk("full.instr", out_instr, 32'h7856_3412);

        // From full: push attempt plus pop -> only pop.
        step("full_pop", 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b1, 1'b0);
        check_all("after_full_pop");
        chk("after_full_pop.count", 32'(count), 32'd3);
        chk("after_full_pop.pc", out_pc, 32'h4);

        // Drain to two, then simultaneous push/pop streaming across wrap.
        step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
        step("pp0", 1'b1, 32'hA000_0010, 32'h10, 1'b1, 1'b0);
        chk("pp0.count", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++)
            step("stream", 1'b1, 32'hB000_0000 + 32'(i), 32'h14 + 32'(i * 4), 1'b1, 1'b0);
        chk("stream.count", 32'(count), 32'd2);
        step("drain2", 1'b0, '0, '0, 1'b1, 1'b0);
        step("drain3", 1'b0, '0, '0, 1'b1, 1'b0);
        step("empty_pop", 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with a simultaneous push at count 3.
        for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'hC000_0000 + 32'(i), 32'h40 + 32'(i * 4), 1'b0, 1'b0);
        step("flush", 1'b1, 32'hCAFE_F00D, 32'h80, 1'b0, 1'b1);
        check_all("post_flush");
        chk("post_flush.instr", out_instr, 32'h0000_0013);
        chk("post_flush.valid", 32'(out_valid), 32'd0);

        // Misalignment flag.
        step("mis6", 1'b1, 32'h1111_1111, 32'h6, 1'b0, 1'b0);
        step("mis8", 1'b1, 32'h2222_2222, 32'h8, 1'b0, 1'b0);
        chk("mis6.flag", 32'(out_misaligned), 32'd1);
        step("pop_mis", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("mis8.flag", 32'(out_misaligned), 32'd0);
        chk("mis8.pc", out_pc, 32'h8);

        // Asynchronous reset mid-cycle at count 2.
        step("pre_rst", 1'b1, 32'h3333_3333, 32'hC, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.count", 32'(count), 32'd0);
        check_all("async_rst");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst_push", 1'b1, 32'h4444_4444, 32'h20, 1'b0, 1'b0);
        check_all("post_rst");
        chk("post_rst.pc", out_pc, 32'h20);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step("final", 1'b0, '0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction entries held (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 SHALL have port in_instr  input  32  fetched instruction word, little-endian assembled.
REQ-006 SHALL have port in_pc  input  32  byte address the instruction was fetched from.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port flush  input  1  discard all held entries (taken branch/redirect).
REQ-009 SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes head entry this cycle.
REQ-011 SHALL have port out_instr  output  32  head instruction word.
REQ-012 SHALL have port out_pc  output  32  head entry PC.
REQ-013 SHALL have port out_misaligned  output  1  head entry PC had bits [1:0] != 0.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries held.

Function
REQ-015 SHALL implement a circular buffer with write pointer, read pointer and occupancy counter, all registered; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 SHALL push (store in_instr, in_pc, in_pc[1:0]!=0) when in_valid && in_ready.
REQ-017 SHALL pop (advance read pointer) when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH) && !flush, combinationally; no write-through when full, even if a pop occurs the same cycle.
REQ-019 SHALL drive out_valid = (count != 0); out_instr/out_pc/out_misaligned SHALL come combinationally from the entry at the read pointer (zero-cycle read latency, one-cycle push-to-visible latency).
REQ-020 SHALL, when empty, drive out_instr = 32'h0000_0013 (NOP), out_pc = 0, out_misaligned = 0.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and update both pointers.
REQ-022 SHALL, when flush is high at a rising edge, set count, read and write pointers to 0 regardless of in_valid/out_ready; any pop handshake in that cycle is still considered consumed by decode, but no push occurs.
REQ-023 SHALL never let count exceed DEPTH nor underflow below 0; a pop request with out_valid=0 SHALL have no effect.
REQ-024 SHALL preserve strict FIFO order; stored data SHALL remain stable while out_valid && !out_ready.
REQ-025 SHALL hold the head entry's out_* values constant across cycles while not popped and not flushed.

Reset
REQ-026 SHALL, while rst_n=0, immediately force count=0, pointers=0, out_valid=0, out_instr=32'h0000_0013, out_pc=0, out_misaligned=0, in_ready=1 (if flush=0).
REQ-027 SHALL discard all entries on reset asserted mid-operation; storage array contents need not be cleared.
REQ-028 SHALL resume accepting pushes on the first rising edge after rst_n deasserts.

Verification
REQ-029 Push PC 0x0,0x4,0x8,0xC with instr 0x78563412,0xF0DEBC9A,... and out_ready=0 -> count=4, in_ready=0, out_pc=0x0, out_instr=0x78563412.
REQ-030 From full, out_ready=1 and in_valid=1 for one cycle -> one pop, no push, count=3, out_pc=0x4.
REQ-031 Count=2, simultaneous push (PC 0x10) and pop -> count stays 2; subsequent pops yield PCs in order; pointers wrap past DEPTH-1 correctly over 10 continuous streaming cycles with count steady.
REQ-032 Count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013; pushed word absent.
REQ-033 Push PC 0x6 -> out_misaligned=1 when at head; PC 0x8 -> 0.
REQ-034 Count=2, assert rst_n=0 between edges -> out_valid=0, count=0 without waiting for clk; after release, push PC 0x20 -> out_pc=0x20 next cycle.
